// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: byte handshake in, start/data/parity/stop serial frame out
//
// Parameters:
//   CLK_FREQ   sysclk frequency in Hz
//   BAUD       line bit rate; one bit lasts DIV = CLK_FREQ/BAUD cycles
//   PARITY_EN  1 inserts a parity bit after data bit 7
//   PARITY_ODD 0 even parity, 1 odd parity (only meaningful with PARITY_EN=1)
//   STOP_BITS  number of stop bits, 1 or 2
//
// Ports:
//   sysclk      single clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_valid    a byte is offered on tx_data
//   tx_data     byte to send
//   tx_ready    high in IDLE only; a byte is taken when tx_valid && tx_ready
//   tx          registered serial line, idles high
//   tx_done_sig one-cycle pulse on the cycle the framer returns to IDLE
//   busy        high while a frame is in flight (state != IDLE)

module uart_tx_framer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done_sig,
    output logic       busy
);

    localparam int            DIV        = CLK_FREQ / BAUD;
    localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
    localparam bit            HAS_PARITY = (PARITY_EN != 0);
    localparam logic          ODD        = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    // Index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic          STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic          tx_next;
    logic          accept;
    logic          bit_end;

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    // Last cycle of the current bit period; never asserted in IDLE.
    assign bit_end  = (state != IDLE) && (baud_cnt == BAUD_LAST);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the value tx takes on the following edge. tx lags the
    // state register by one cycle, which puts the start-bit falling edge one
    // edge after acceptance and keeps every bit exactly DIV cycles long.
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shreg[0];
                if (bit_end && (bit_idx == 4'd7)) begin
                    state_next = HAS_PARITY ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_next = parity_bit;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_end && (stop_idx == STOP_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Baud counter: held at zero in IDLE so START begins a full period on
    // the acceptance edge, then wraps at every bit boundary.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if ((state == IDLE) || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 4'd0;
        end else if (state != DATA) begin
            bit_idx <= 4'd0;
        end else if (bit_end) begin
            bit_idx <= (bit_idx == 4'd7) ? 4'd0 : bit_idx + 4'd1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            stop_idx <= 1'b0;
        end else if (state != STOP) begin
            stop_idx <= 1'b0;
        end else if (bit_end) begin
            stop_idx <= ~stop_idx;
        end
    end

    // Byte and its parity are captured on acceptance, so later tx_data
    // changes cannot reach the frame in flight.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= 8'h00;
            parity_bit <= 1'b0;
        end else if (accept) begin
            shreg      <= tx_data;
            parity_bit <= (^tx_data) ^ ODD;
        end else if ((state == DATA) && bit_end) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tx          <= 1'b1;
            tx_done_sig <= 1'b0;
        end else begin
            tx          <= tx_next;
            tx_done_sig <= (state == STOP) && (state_next == IDLE);
        end
    end

endmodule
